// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, address widths, and the
// symbolic indices into the branch-target table.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned IDX_W = 4;

    // Entries in the branch-target table, one slot per program branch site
    localparam logic [IDX_W-1:0] PROG1_LOOP       = 4'd0;
    localparam logic [IDX_W-1:0] PROG2_LOOP       = 4'd1;
    localparam logic [IDX_W-1:0] PROG3_LOOP       = 4'd2;
    localparam logic [IDX_W-1:0] PROG1_EXIT       = 4'd3;
    localparam logic [IDX_W-1:0] PROG2_EXIT       = 4'd4;
    localparam logic [IDX_W-1:0] PROG3_EXIT       = 4'd5;
    localparam logic [IDX_W-1:0] PROG1_SKIP       = 4'd6;
    localparam logic [IDX_W-1:0] PROG2_SKIP       = 4'd7;
    localparam logic [IDX_W-1:0] PROG3_LAST_ENTRY = 4'd8;

endpackage

// File: rtl/prog_ctr_branch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/prog_ctr_branch.sv
// Fetch-side program counter: sequences a run from Start to Halt, follows
// taken branches through the zero-latency target table, counts retirements.
module prog_ctr_branch #(
    parameter int unsigned    PC_W     = cpu_pkg::PC_W,
    parameter int unsigned    IDX_W    = cpu_pkg::IDX_W,
    parameter int unsigned    CNT_W    = 16,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic [IDX_W-1:0] BranchIdx,
    input  logic             Halt,
    input  logic [PC_W-1:0]  LutTarget,
    output logic [IDX_W-1:0] LutAddr,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow,
    output logic [CNT_W-1:0] InstCount
);

    import cpu_pkg::*;

    pc_state_t state;
    logic      cnt_inc;
    logic      cnt_clr;

    assign LutAddr = BranchIdx;

    // Every non-stalled RUN cycle retires one instruction, halt included
    assign cnt_inc = (state == RUN) && !Stall;
    assign cnt_clr = (state != RUN) && Start;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_inst_cnt (
        .clk  (Clk),
        .rst  (Reset),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .count(InstCount)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            ProgCtr  <= START_PC;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state    <= RUN;
                        ProgCtr  <= START_PC;
                        Busy     <= 1'b1;
                        Done     <= 1'b0;
                        Overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (Stall) begin
                        state <= RUN;
                    end else if (Halt) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else if (BranchEn) begin
                        ProgCtr <= LutTarget;
                    end else begin
                        ProgCtr <= ProgCtr + 1'b1;
                        if (ProgCtr == '1) begin
                            Overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr_branch.sv
// Directed bench for prog_ctr_branch; a second instance with a 4-bit
// counter exposes InstCount saturation within a short run.
module tb_prog_ctr_branch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Stall;
    logic       BranchEn;
    logic [3:0] BranchIdx;
    logic       Halt;
    logic [7:0] LutTarget;

    logic [3:0]  LutAddr;
    logic [7:0]  ProgCtr;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic [15:0] InstCount;

    logic [3:0] s_LutAddr;
    logic [7:0] s_ProgCtr;
    logic       s_Busy;
    logic       s_Done;
    logic       s_Overflow;
    logic [3:0] s_InstCount;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    prog_ctr_branch #(
        .PC_W(8), .IDX_W(4), .CNT_W(16), .START_PC(8'd0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BranchIdx(BranchIdx), .Halt(Halt),
        .LutTarget(LutTarget), .LutAddr(LutAddr), .ProgCtr(ProgCtr),
        .Busy(Busy), .Done(Done), .Overflow(Overflow), .InstCount(InstCount)
    );

    prog_ctr_branch #(
        .PC_W(8), .IDX_W(4), .CNT_W(4), .START_PC(8'd0)
    ) u_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BranchIdx(BranchIdx), .Halt(Halt),
        .LutTarget(LutTarget), .LutAddr(s_LutAddr), .ProgCtr(s_ProgCtr),
        .Busy(s_Busy), .Done(s_Done), .Overflow(s_Overflow), .InstCount(s_InstCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] pc, input logic [15:0] cnt,
                           input logic busy, input logic done, input logic ovf);
        chk({tag, ".pc"},   ProgCtr,   pc);
        chk({tag, ".cnt"},  InstCount, cnt);
        chk({tag, ".busy"}, Busy,      busy);
        chk({tag, ".done"}, Done,      done);
        chk({tag, ".ovf"},  Overflow,  ovf);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
        BranchIdx = 4'd0; Halt = 1'b0; LutTarget = 8'd0;
        #2;
        chk_all("reset", 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        step();
        Reset = 1'b0;
        step();
        chk_all("idle", 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // Start and sequential fetch
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk_all("start", 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            BranchIdx = 4'(i + 3);
            #1;
            chk("lutaddr", LutAddr, 32'(i + 3));
            step();
            chk("seq.pc",  ProgCtr,   32'(i));
            chk("seq.cnt", InstCount, 32'(i));
        end
        chk("seq.busy", Busy, 1);
        step();
        step();
        chk_all("pc7", 8'd7, 16'd7, 1'b1, 1'b0, 1'b0);

        // Stall beats both Halt and BranchEn
        Stall = 1'b1; BranchEn = 1'b1; Halt = 1'b1; LutTarget = 8'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 8'd7, 16'd7, 1'b1, 1'b0, 1'b0);
        end
        Stall = 1'b0; BranchEn = 1'b0; Halt = 1'b0;
        step(); step(); step();
        chk_all("pc10", 8'd10, 16'd10, 1'b1, 1'b0, 1'b0);

        // Taken branch through the table, then sequential continuation
        BranchEn = 1'b1; BranchIdx = cpu_pkg::PROG3_LOOP; LutTarget = 8'd235;
        #1;
        chk("lutaddr.br", LutAddr, 2);
        step();
        BranchEn = 1'b0;
        chk_all("branch", 8'd235, 16'd11, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("after_br", 8'd236, 16'd12, 1'b1, 1'b0, 1'b0);
        chk("sat.cnt12", s_InstCount, 12);

        // Branch to self: PC constant, count keeps going
        BranchEn = 1'b1; LutTarget = 8'd236;
        step(); step();
        BranchEn = 1'b0;
        chk_all("selfloop", 8'd236, 16'd14, 1'b1, 1'b0, 1'b0);

        // Start during RUN is ignored
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk_all("start_in_run", 8'd237, 16'd15, 1'b1, 1'b0, 1'b0);

        BranchEn = 1'b1; LutTarget = 8'd131;
        step();
        chk_all("br131", 8'd131, 16'd16, 1'b1, 1'b0, 1'b0);
        chk("sat.cnt16", s_InstCount, 15);

        // Halt beats BranchEn
        Halt = 1'b1; LutTarget = 8'd50;
        step();
        Halt = 1'b0;
        chk_all("halt", 8'd131, 16'd17, 1'b0, 1'b1, 1'b0);
        chk("sat.cnt17", s_InstCount, 15);
        step(); step();
        BranchEn = 1'b0;
        chk_all("done_hold", 8'd131, 16'd17, 1'b0, 1'b1, 1'b0);

        // Restart from DONE
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk_all("restart", 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        chk("sat.restart", s_InstCount, 0);

        // Wrap past 255 sets sticky Overflow
        BranchEn = 1'b1; LutTarget = 8'd250;
        step();
        BranchEn = 1'b0;
        chk_all("br250", 8'd250, 16'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("wrap.pc",  ProgCtr,   32'((250 + i) % 256));
            chk("wrap.cnt", InstCount, 32'(i + 1));
            chk("wrap.ovf", Overflow,  (i >= 6) ? 1 : 0);
        end
        BranchEn = 1'b1; LutTarget = 8'd5;
        step();
        BranchEn = 1'b0;
        chk_all("ovf_sticky", 8'd5, 16'd10, 1'b1, 1'b0, 1'b1);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        chk_all("ovf_done", 8'd5, 16'd11, 1'b0, 1'b1, 1'b1);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk_all("ovf_clr", 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle
        step(); step(); step();
        chk_all("pre_rst", 8'd3, 16'd3, 1'b1, 1'b0, 1'b0);
        #3;
        Reset = 1'b1;
        Start = 1'b1;
        #1;
        chk_all("async_rst", 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rst_start", 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        Start = 1'b0;
        Reset = 1'b0;
        step();
        chk_all("post_rst", 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_ctr_branch.md
Name: prog_ctr_branch

Overview:
- Fetch-side program counter and the initiator of the branch-target lookup table.
- Drives the 4-bit table index and consumes the 8-bit absolute target the table returns combinationally.
- Sequences one program run: start handshake, sequential/branch/stall updates, halt, done.
- Sits between the control decoder (branch/halt/stall requests) and instruction memory (fed by ProgCtr).

Parameters:
- PC_W, 8, program counter width; instruction memory depth is 2**PC_W.
- IDX_W, 4, branch-target table index width.
- CNT_W, 16, retired-instruction counter width.
- START_PC, 0, PC value loaded on Start.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset; clears all state immediately on assertion.
- Start  input  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- Stall  input  1  hold PC this cycle; no retire.
- BranchEn  input  1  branch taken this cycle (condition already resolved by the decoder).
- BranchIdx  input  IDX_W  table entry selected by the branch instruction.
- Halt  input  1  current instruction is the program terminator.
- LutTarget  input  PC_W  target returned by the table for LutAddr (same cycle).
- LutAddr  output  IDX_W  index to the table.
- ProgCtr  output  PC_W  address of the current instruction.
- Busy  output  1  high in RUN.
- Done  output  1  high in DONE; held until the next Start or Reset.
- Overflow  output  1  sticky; set when the PC wrapped past 2**PC_W-1.
- InstCount  output  CNT_W  instructions retired in the current run; saturates.

Behaviour:
- States: IDLE, RUN, DONE, encoded as a 2-bit enum.
- Reset (async, any state, mid-run included) forces:
  - state=IDLE, ProgCtr=START_PC, Busy=0, Done=0, Overflow=0, InstCount=0.
- LutAddr = BranchIdx at all times, purely combinational. The table is zero-latency, so LutTarget is sampled in the same cycle it is requested.
- IDLE or DONE, Start=1:
  - next cycle: state=RUN, ProgCtr=START_PC, InstCount=0, Overflow=0, Done=0.
  - Other inputs are ignored in IDLE/DONE.
- RUN, per-cycle priority (highest first):
  1. Stall=1: ProgCtr, InstCount and state hold; BranchEn and Halt are ignored.
  2. Halt=1: state->DONE next cycle; ProgCtr holds at the halt address; InstCount+1. Halt beats BranchEn.
  3. BranchEn=1: ProgCtr<=LutTarget next cycle; InstCount+1. Taken-branch latency is 1 cycle with no bubble.
  4. Otherwise: ProgCtr<=ProgCtr+1 (modulo 2**PC_W); InstCount+1.
- Wrap: a sequential increment from 2**PC_W-1 yields 0 and sets Overflow. The run continues. Branch targets never set Overflow.
- InstCount saturates at 2**CNT_W-1; it never wraps.
- Start asserted during RUN is ignored; a run cannot be restarted except via Halt->DONE or Reset.
- A branch whose target equals the current PC is legal (tight loop); ProgCtr stays constant and InstCount keeps incrementing.
- All outputs except LutAddr are registered.

Decomposition:
- Shared package (cpu_pkg) holds:
  - pc_state_t enum {IDLE, RUN, DONE};
  - PC_W and IDX_W constants, shared with the table and instruction memory;
  - named branch-index constants: PROG1_LOOP=0, PROG2_LOOP=1, ... PROG3_LAST_ENTRY=8.
- No sub-module needed. The saturating counter is optionally factored as sat_counter (parameter CNT_W; inc/clr inputs).

Test Plan:
- Reset then Start pulse, no other inputs for 5 cycles -> ProgCtr 0,1,2,3,4; Busy=1; InstCount=5; LutAddr follows BranchIdx.
- At PC=10, BranchEn=1, BranchIdx=2, table returns 235 -> next cycle ProgCtr=235, InstCount+1; then increments to 236.
- Stall=1 for 3 cycles with BranchEn=1 and Halt=1 at PC=7 -> ProgCtr stays 7, InstCount unchanged, state stays RUN.
- Halt=1 and BranchEn=1 together at PC=131 -> DONE, Done=1, Busy=0, ProgCtr=131; a later Start restarts at 0 with InstCount=0.
- Run sequentially from PC=250 for 8 cycles -> ProgCtr wraps 255->0, Overflow=1 and stays 1 until the next Start.
- Assert Reset asynchronously mid-RUN, between clock edges -> all outputs clear immediately without waiting for a clock edge; state IDLE; Start is ignored while Reset is high.
